// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM for a 9-bit instruction set.
// Sequences FETCH/EXEC/MEM/WB, owns the PC and drives the datapath strobes.
module ctrl_fsm #(
   parameter int PC_W     = 8,
   parameter int START_PC = 0
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic            Start,
   input  logic [8:0]      Instruction,
   input  logic            Zero,
   output logic [PC_W-1:0] InstAddr,
   output logic [1:0]      ALU_OP,
   output logic [1:0]      ALU_Func,
   output logic [7:0]      Imm,
   output logic            RegWrite,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            Done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALTED = 3'd5;

   localparam logic [PC_W-1:0] PC_RST = PC_W'(START_PC);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   logic [2:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [8:0]      ir_q, ir_d;

   logic [1:0]  op, fn;
   logic [31:0] off32;
   logic        is_mem, is_lw, is_sw, is_beq, is_jmp, is_halt;

   assign op      = ir_q[8:7];
   assign fn      = ir_q[6:5];
   assign off32   = {{27{ir_q[4]}}, ir_q[4:0]};
   assign is_sw   = (op == 2'b01) && (fn == 2'b00);
   assign is_lw   = (op == 2'b01) && (fn == 2'b01);
   assign is_mem  = is_sw || is_lw;
   assign is_beq  = (op == 2'b00) && fn[0];
   assign is_jmp  = (op == 2'b11) && (fn == 2'b10);
   assign is_halt = (op == 2'b11) && (fn == 2'b11);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (Start) begin
               pc_d    = PC_RST;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            ir_d    = Instruction;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_mem) begin
               state_d = S_MEM;
            end else if (is_beq || is_jmp) begin
               // Zero only matters on this edge; offset wraps modulo 2^PC_W.
               pc_d    = (is_jmp || Zero) ? pc_q + off32[PC_W-1:0] : pc_q + PC_ONE;
               state_d = S_FETCH;
            end else if (is_halt) begin
               state_d = S_HALTED;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (is_lw) begin
               state_d = S_WB;
            end else begin
               pc_d    = pc_q + PC_ONE;
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         pc_q    <= PC_RST;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Outputs decode straight from flops so reset clears them without a clock.
   assign InstAddr = pc_q;
   assign ALU_OP   = (state_q == S_EXEC) ? op : 2'b00;
   assign ALU_Func = (state_q == S_EXEC) ? fn : 2'b00;
   assign Imm      = {3'b000, ir_q[4:0]};
   assign RegWrite = (state_q == S_WB);
   assign MemRead  = (state_q == S_MEM) && is_lw;
   assign MemWrite = (state_q == S_MEM) && is_sw;
   assign Done     = (state_q == S_HALTED);

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: a per-cycle vector table over a small program,
// plus hand sequences for async reset, PC wrap and a zero-offset branch.
module tb_ctrl_fsm;

   logic       CLK, Reset, Start, Zero;
   logic [8:0] Instruction;
   logic [7:0] InstAddr, Imm;
   logic [1:0] ALU_OP, ALU_Func;
   logic       RegWrite, MemRead, MemWrite, Done;

   logic [8:0] imem [256];
   assign Instruction = imem[InstAddr];

   ctrl_fsm #(.PC_W(8), .START_PC(0)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Instruction(Instruction), .Zero(Zero),
      .InstAddr(InstAddr), .ALU_OP(ALU_OP), .ALU_Func(ALU_Func), .Imm(Imm),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Done(Done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        start;
      logic        zero;
      logic [23:0] exp;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl [$];

   logic [23:0] act;
   assign act = {InstAddr, ALU_OP, ALU_Func, RegWrite, MemRead, MemWrite, Done, Imm};

   function automatic logic [23:0] ev(input logic [7:0] pc, input logic [1:0] aop, input logic [1:0] afn,
                                      input logic rw, input logic mr, input logic mw, input logic dn,
                                      input logic [7:0] imm);
      return {pc, aop, afn, rw, mr, mw, dn, imm};
   endfunction

   function automatic logic [8:0] ins(input logic [1:0] op, input logic [1:0] fn, input logic [4:0] f);
      return {op, fn, f};
   endfunction

   function automatic vec_t mk(input logic st, input logic z, input logic [23:0] e);
      vec_t v;
      v.start = st; v.zero = z; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [23:0] e);
      n_cmp++;
      if (act !== e) begin
         n_bad++;
         $display("FAIL %s: got pc=%0d op=%b fn=%b rw/mr/mw/dn=%b imm=%0d, want pc=%0d op=%b fn=%b rw/mr/mw/dn=%b imm=%0d",
                  nm, act[23:16], act[15:14], act[13:12], act[11:8], act[7:0],
                  e[23:16], e[15:14], e[13:12], e[11:8], e[7:0]);
      end
   endtask

   task automatic step(input logic st, input logic z, input string nm, input logic [23:0] e);
      Start = st;
      Zero  = z;
      @(posedge CLK);
      #1;
      chk(nm, e);
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Zero = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = '0;
      imem[0] = ins(2'b00, 2'b00, 5'd3);      // ADD
      imem[1] = ins(2'b11, 2'b10, 5'd4);      // JMP +4
      imem[3] = ins(2'b11, 2'b10, 5'd2);      // JMP +2
      imem[5] = ins(2'b00, 2'b01, 5'b11110);  // BEQ -2
      imem[6] = ins(2'b01, 2'b00, 5'd1);      // SW
      imem[7] = ins(2'b01, 2'b01, 5'd2);      // LW
      imem[8] = ins(2'b01, 2'b10, 5'd0);      // SLT
      imem[9] = ins(2'b11, 2'b11, 5'd0);      // HALT

      tbl.push_back(mk(1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, ev(0, 0, 0, 0, 0, 0, 0, 3)));
      tbl.push_back(mk(0, 0, ev(0, 0, 0, 1, 0, 0, 0, 3)));
      tbl.push_back(mk(0, 1, ev(1, 0, 0, 0, 0, 0, 0, 3)));
      tbl.push_back(mk(1, 0, ev(1, 3, 2, 0, 0, 0, 0, 4)));
      tbl.push_back(mk(1, 0, ev(5, 0, 0, 0, 0, 0, 0, 4)));
      tbl.push_back(mk(1, 0, ev(5, 0, 1, 0, 0, 0, 0, 30)));
      tbl.push_back(mk(0, 1, ev(3, 0, 0, 0, 0, 0, 0, 30)));
      tbl.push_back(mk(0, 0, ev(3, 3, 2, 0, 0, 0, 0, 2)));
      tbl.push_back(mk(0, 1, ev(5, 0, 0, 0, 0, 0, 0, 2)));
      tbl.push_back(mk(0, 1, ev(5, 0, 1, 0, 0, 0, 0, 30)));
      tbl.push_back(mk(0, 0, ev(6, 0, 0, 0, 0, 0, 0, 30)));
      tbl.push_back(mk(0, 0, ev(6, 1, 0, 0, 0, 0, 0, 1)));
      tbl.push_back(mk(0, 1, ev(6, 0, 0, 0, 0, 1, 0, 1)));
      tbl.push_back(mk(0, 1, ev(7, 0, 0, 0, 0, 0, 0, 1)));
      tbl.push_back(mk(0, 0, ev(7, 1, 1, 0, 0, 0, 0, 2)));
      tbl.push_back(mk(0, 0, ev(7, 0, 0, 0, 1, 0, 0, 2)));
      tbl.push_back(mk(1, 0, ev(7, 0, 0, 1, 0, 0, 0, 2)));
      tbl.push_back(mk(0, 0, ev(8, 0, 0, 0, 0, 0, 0, 2)));
      tbl.push_back(mk(0, 0, ev(8, 1, 2, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, ev(8, 0, 0, 1, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, ev(9, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, ev(9, 3, 3, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, ev(9, 0, 0, 0, 0, 0, 1, 0)));
      tbl.push_back(mk(0, 0, ev(9, 0, 0, 0, 0, 0, 1, 0)));
      tbl.push_back(mk(1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, ev(0, 0, 0, 0, 0, 0, 0, 3)));
      tbl.push_back(mk(0, 0, ev(0, 0, 0, 1, 0, 0, 0, 3)));
      tbl.push_back(mk(0, 0, ev(1, 0, 0, 0, 0, 0, 0, 3)));

      #2 Reset = 1'b0;
      #1 chk("reset_async", ev(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge CLK);
      Reset = 1'b1;
      step(0, 1, "idle_no_start", ev(0, 0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) step(tbl[i].start, tbl[i].zero, $sformatf("vec%0d", i), tbl[i].exp);

      // SW aborted by reset while in MEM
      imem[0] = ins(2'b01, 2'b00, 5'd1);
      @(negedge CLK);
      Reset = 1'b0;
      #1 chk("reset_mid_prog", ev(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge CLK);
      Reset = 1'b1;
      step(1, 0, "sw_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0));
      step(0, 0, "sw_exec",  ev(0, 1, 0, 0, 0, 0, 0, 1));
      step(0, 0, "sw_mem",   ev(0, 0, 0, 0, 0, 1, 0, 1));
      #3 Reset = 1'b0;
      #1 chk("sw_reset_async", ev(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge CLK);
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 0, $sformatf("post_reset_idle%0d", i), ev(0, 0, 0, 0, 0, 0, 0, 0));

      // JMP -1 from 0 to 255, LW there, PC wraps back to 0
      imem[0]   = ins(2'b11, 2'b10, 5'b11111);
      imem[255] = ins(2'b01, 2'b01, 5'd4);
      step(1, 0, "wrap_fetch0",  ev(0,   0, 0, 0, 0, 0, 0, 0));
      step(0, 0, "wrap_exec0",   ev(0,   3, 2, 0, 0, 0, 0, 31));
      step(0, 0, "wrap_fetch255", ev(255, 0, 0, 0, 0, 0, 0, 31));
      step(0, 0, "lw_exec",      ev(255, 1, 1, 0, 0, 0, 0, 4));
      step(0, 0, "lw_mem",       ev(255, 0, 0, 0, 1, 0, 0, 4));
      step(0, 0, "lw_wb",        ev(255, 0, 0, 1, 0, 0, 0, 4));
      step(0, 0, "lw_wrap_pc",   ev(0,   0, 0, 0, 0, 0, 0, 4));

      // BEQ with offset 0 loops on itself while Zero=1
      imem[0] = ins(2'b00, 2'b01, 5'd0);
      step(0, 1, "loop_exec0",  ev(0, 0, 1, 0, 0, 0, 0, 0));
      step(0, 1, "loop_fetch",  ev(0, 0, 0, 0, 0, 0, 0, 0));
      step(0, 1, "loop_exec1",  ev(0, 0, 1, 0, 0, 0, 0, 0));
      step(0, 0, "loop_exit",   ev(1, 0, 0, 0, 0, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
